buzzer_tone_driver: RTL and testbench



---
 rtl/buzzer_tone_driver.sv | 116 +++++++++++
 tb/tb_buzzer_tone_driver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/buzzer_tone_driver.sv
// Piezo square-wave driver: phase-aligned start on request, and on release the
// current high half-period always completes so the pin never carries a runt pulse.
module buzzer_tone_driver #(
  parameter int HALF_PERIOD = 12500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic buzz,
  output logic buzzer_out,
  output logic active
);

  localparam int              CW       = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0]   CNT_TC   = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TONE  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic          req_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          active_q, active_d;
  logic          tc_s;

  assign tc_s = (cnt_q == CNT_TC);

  // Next-state logic; DRAIN holds the pin high until the running half ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (req_q) begin
          state_d = ST_TONE;
          out_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
        end
      end
      ST_TONE: begin
        if (tc_s) begin
          cnt_d = CNT_ZERO;
          out_d = ~out_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          out_d = out_q;
        end
        if (req_q) begin
          state_d = ST_TONE;
        end else if (!out_q) begin
          // Low half: stop at once, never begin another high half.
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          out_d   = 1'b0;
        end else if (tc_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tc_s) begin
          cnt_d   = CNT_ZERO;
          out_d   = 1'b0;
          state_d = req_q ? ST_TONE : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          out_d   = 1'b1;
          state_d = req_q ? ST_TONE : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        out_d   = 1'b0;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // Request is sampled once so every decision sees the same synchronous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= en & buzz;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      out_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      active_q <= active_d;
    end
  end

  assign buzzer_out = out_q;
  assign active     = active_q;

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Directed bench for buzzer_tone_driver with HALF_PERIOD=4.
module tb_buzzer_tone_driver;

  logic clk;
  logic rst_n;
  logic en;
  logic buzz;
  logic buzzer_out;
  logic active;

  int n_cmp;
  int n_fail;

  buzzer_tone_driver #(.HALF_PERIOD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .buzz       (buzz),
    .buzzer_out (buzzer_out),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    buzz   = 1'b1;

    // Reset held with request asserted
    repeat (3) tick();
    check("rst_out", buzzer_out, 1'b0);
    check("rst_active", active, 1'b0);

    rst_n = 1'b1;
    tick();
    check("post_rst_edge1_out", buzzer_out, 1'b0);
    check("post_rst_edge1_active", active, 1'b0);
    tick();
    check("post_rst_edge2_out", buzzer_out, 1'b1);
    check("post_rst_edge2_active", active, 1'b1);

    // Steady tone: 1111 0000 x5
    for (int i = 0; i < 40; i++) begin
      if (i != 0) tick();
      check($sformatf("steady_out[%0d]", i), buzzer_out, ((i / 4) % 2) == 0);
      check($sformatf("steady_active[%0d]", i), active, 1'b1);
    end

    // Release in high half: first high sample, then drop buzz
    tick();
    check("rel_hi_start", buzzer_out, 1'b1);
    buzz = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("rel_hi_out[%0d]", i), buzzer_out, i < 4);
      check($sformatf("rel_hi_active[%0d]", i), active, i < 4);
    end

    // Release in low half
    buzz = 1'b1;
    tick();
    check("rel_lo_req", buzzer_out, 1'b0);
    tick();
    check("rel_lo_rise", buzzer_out, 1'b1);
    repeat (4) tick();
    check("rel_lo_low", buzzer_out, 1'b0);
    check("rel_lo_low_active", active, 1'b1);
    en = 1'b0;
    tick();
    check("rel_lo_e1_active", active, 1'b1);
    check("rel_lo_e1_out", buzzer_out, 1'b0);
    tick();
    check("rel_lo_e2_active", active, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rel_lo_idle_out[%0d]", i), buzzer_out, 1'b0);
      check($sformatf("rel_lo_idle_active[%0d]", i), active, 1'b0);
    end

    // Gating: en low, buzz high
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("gate_out[%0d]", i), buzzer_out, 1'b0);
      check($sformatf("gate_active[%0d]", i), active, 1'b0);
    end

    // DRAIN re-entry: waveform must match an uninterrupted tone
    en = 1'b1;
    tick();
    check("reent_req", buzzer_out, 1'b0);
    for (int j = 0; j < 24; j++) begin
      tick();
      check($sformatf("reent_out[%0d]", j), buzzer_out, ((j / 4) % 2) == 0);
      check($sformatf("reent_active[%0d]", j), active, 1'b1);
      if (j == 0) buzz = 1'b0;
      if (j == 1) buzz = 1'b1;
    end

    // Async reset while draining
    tick();
    check("drain_hi", buzzer_out, 1'b1);
    buzz = 1'b0;
    tick();
    tick();
    check("drain_out", buzzer_out, 1'b1);
    check("drain_active", active, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", buzzer_out, 1'b0);
    check("async_rst_active", active, 1'b0);
    #3;
    rst_n = 1'b1;
    repeat (6) tick();
    check("after_rst_out", buzzer_out, 1'b0);
    check("after_rst_active", active, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
